apb_uart_rx: RTL and testbench
==============================

Name: apb_uart_rx

Overview:
- APB slave UART receiver that fills the UART select slot on the APB bus alongside the GPIO slave.
- Deserialises 8N1 frames from the `rx` pin using 16x oversampling and buffers received bytes in a FIFO.
- Exposes data, status, baud divider and control registers to the master bridge over a one-wait-state APB access.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; power of 2, range 2..16.
- DEFAULT_DIV, 16'd1, reset value of the BAUDDIV register.

Ports:
- PCLK  input  1  sole clock; all logic on rising edge.
- PRESET  input  1  synchronous, active-high reset.
- PSEL  input  1  slave select from bridge.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  5  byte address; only PADDR[3:2] are decoded, PADDR[4] must be 0.
- PWDATA  input  32  write data.
- PRDATA  output  32  registered read data.
- PREADY  output  1  transfer completion.
- rx  input  1  asynchronous serial line, idles high.
- rx_irq  output  1  registered interrupt: FIFO non-empty AND CTRL.irq_en.

Behaviour:
- Reset values: PRDATA=0, PREADY=0, rx_irq=0, FIFO empty, sticky flags=0, BAUDDIV=DEFAULT_DIV, CTRL=0x1 (enabled, irq off), FSM=IDLE, both synchroniser flops=1.
- APB handshake: access phase always takes exactly 2 cycles.
  - First cycle with PSEL&PENABLE: PREADY=0; the slave registers PRDATA and performs any write or pop.
  - Second cycle: PREADY=1.
  - PREADY returns to 0 the cycle after that, even if PSEL stays high.
  - PRDATA holds its value until the next read.
- Register map:
  - 0x00 RXDATA (R): bits[7:0] = FIFO head and pops it; returns 0 with no side effect if empty. Writes ignored.
  - 0x04 STATUS: [0] not_empty, [1] full, [2] overrun (sticky), [3] frame_err (sticky), [4] busy (FSM≠IDLE), [12:8] count. Writing 1 to bit 2 or bit 3 clears that bit; all other bits are read-only.
  - 0x08 BAUDDIV (RW): [15:0]. A write also resets the tick counter.
  - 0x0C CTRL (RW): [0] enable, [1] irq_en, [2] flush (self-clearing, reads 0; empties FIFO next edge).
  - Addresses with PADDR[4]=1 read 0 and ignore writes.
- Baud tick: 16-bit counter counts 0..BAUDDIV, tick at BAUDDIV, so tick period = BAUDDIV+1 cycles and bit period = 16*(BAUDDIV+1) cycles.
- rx passes through a 2-flop synchroniser; the FSM sees rx_s.
- FSM (advances only on tick, except IDLE):
  - IDLE: enable=1 and falling edge of rx_s → START; clear the 4-bit tick counter.
  - START: at tick count 7 sample rx_s. If 1 → IDLE (false start). If 0 → DATA, bit index 0, tick counter cleared.
  - DATA: every 16th tick sample rx_s into shift register, LSB first. After bit 7 → STOP.
  - STOP: at 16th tick sample rx_s.
    - If 1: push byte to FIFO. If FIFO is full, drop the byte and set overrun.
    - If 0: set frame_err, discard byte.
    - Either way → IDLE.
- Clearing enable mid-frame returns the FSM to IDLE next cycle; the partial byte is discarded and FIFO contents are kept.
- Simultaneous push and pop: both occur and count is unchanged. A push while full with a simultaneous pop succeeds (no overrun).
- Flush and push in the same cycle: flush wins; FIFO ends empty.
- A W1C clear and a new error in the same cycle: the flag ends up set.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- PRESET asserted mid-frame or mid-access: all state returns to reset values on the next edge, and that access completes with no PREADY pulse.

Test Plan:
- BAUDDIV=1 (bit period 32 cycles), send frame 0xA5 → STATUS reads 0x00000101; RXDATA read returns 0x000000A5 with PREADY high exactly in the 2nd access cycle; STATUS then reads 0x00000000.
- Send 0x3C with stop bit driven 0 → STATUS[3]=1, count=0. Write 0x8 to STATUS → STATUS[3]=0.
- Send 9 bytes 0x01..0x09 without reading (FIFO_DEPTH=8) → STATUS full=1, overrun=1, count=8. Reads return 0x01..0x08, then a ninth read returns 0.
- Pulse rx low for 4 cycles at BAUDDIV=1 → false start: FSM returns to IDLE, count=0, no error flags.
- Assert PRESET at bit 4 of a frame, then release and send 0x55 → only 0x55 is received. BAUDDIV reads 0x0001 and CTRL reads 0x1 after reset.
- Set CTRL=0x3 and send 0x7E → rx_irq rises after the stop-bit sample. Reading RXDATA → rx_irq falls the following cycle. Write CTRL flush with 2 bytes queued → count=0.

Source files
------------

// File: rtl/apb_uart_rx_if.sv
`default_nettype none
// ============================================================================
// apb_uart_rx_if : APB bus bundle between the master bridge and apb_uart_rx
// Revision 1.0
// ============================================================================
interface apb_uart_rx_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface
`default_nettype wire

// File: rtl/apb_uart_rx.sv
`default_nettype none
// ============================================================================
// apb_uart_rx : APB slave 8N1 UART receiver, 16x oversampling, receive FIFO
// Revision 1.0
// ============================================================================
module apb_uart_rx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd1
) (
  input  logic          PCLK,
  input  logic          PRESET,
  apb_uart_rx_if.slave  apb,
  input  logic          rx,
  output logic          rx_irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_RXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  logic             sync1_q, sync2_q, rxs_prev_q;
  logic [15:0]      baud_q, div_cnt_q;
  logic             en_q, irq_en_q;
  state_e           state_q, state_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovr_q, fe_q;
  logic [31:0]      prdata_q, prdata_d;
  logic             pready_q, acc_q, irq_q;

  logic rx_s, tick, push_req, frame_set;
  logic access_first, wr_en, rd_en, pop, flush, push_ok, ovr_set;
  logic clr_ovr, clr_fe, fifo_empty, fifo_full, busy;
  logic unused_bits;

  assign rx_s       = sync2_q;
  assign tick       = (div_cnt_q == baud_q);
  assign busy       = (state_q != ST_IDLE);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  // An access is claimed once; acc_q blocks re-triggering while PSEL/PENABLE linger.
  assign access_first = apb.PSEL & apb.PENABLE & ~acc_q;
  assign wr_en        = access_first &  apb.PWRITE & ~apb.PADDR[4];
  assign rd_en        = access_first & ~apb.PWRITE & ~apb.PADDR[4];
  assign pop          = rd_en & (apb.PADDR[3:2] == ADDR_RXDATA) & ~fifo_empty;
  assign flush        = wr_en & (apb.PADDR[3:2] == ADDR_CTRL) & apb.PWDATA[2];
  assign clr_ovr      = wr_en & (apb.PADDR[3:2] == ADDR_STATUS) & apb.PWDATA[2];
  assign clr_fe       = wr_en & (apb.PADDR[3:2] == ADDR_STATUS) & apb.PWDATA[3];
  assign push_ok      = push_req & (~fifo_full | pop);
  assign ovr_set      = push_req & fifo_full & ~pop & ~flush;

  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = pready_q;
  assign rx_irq     = irq_q;
  assign unused_bits = ^{apb.PWDATA[31:16], apb.PADDR[1:0]};

  always_comb begin
    prdata_d = '0;
    if (!apb.PADDR[4]) begin
      case (apb.PADDR[3:2])
        ADDR_RXDATA: if (!fifo_empty) prdata_d = {24'd0, mem_q[rd_ptr_q]};
        ADDR_STATUS: prdata_d = {19'd0, 5'(count_q), 3'd0, busy, fe_q, ovr_q,
                                 fifo_full, ~fifo_empty};
        ADDR_BAUD:   prdata_d = {16'd0, baud_q};
        ADDR_CTRL:   prdata_d = {30'd0, irq_en_q, en_q};
        default:     prdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (!en_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rxs_prev_q && !rx_s) begin
            state_d = ST_START;
            tcnt_d  = 4'd0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tcnt_q == 4'd7) begin
              tcnt_d  = 4'd0;
              bit_d   = 3'd0;
              state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tcnt_d = tcnt_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            tcnt_d = tcnt_q + 4'd1;
            if (tcnt_q == 4'd15) begin
              shift_d = {rx_s, shift_q[7:1]};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            tcnt_d = tcnt_q + 4'd1;
            if (tcnt_q == 4'd15) begin
              push_req  = rx_s;
              frame_set = ~rx_s;
              state_d   = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
      baud_q     <= DEFAULT_DIV;
      div_cnt_q  <= '0;
      en_q       <= 1'b1;
      irq_en_q   <= 1'b0;
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      acc_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      acc_q      <= apb.PSEL & apb.PENABLE;
      pready_q   <= access_first;
      irq_q      <= ~fifo_empty & irq_en_q;

      if (access_first && !apb.PWRITE) prdata_q <= prdata_d;

      if (wr_en && apb.PADDR[3:2] == ADDR_BAUD) begin
        baud_q    <= apb.PWDATA[15:0];
        div_cnt_q <= '0;
      end else if (tick) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + 16'd1;
      end

      if (wr_en && apb.PADDR[3:2] == ADDR_CTRL) begin
        en_q     <= apb.PWDATA[0];
        irq_en_q <= apb.PWDATA[1];
      end

      // Set beats clear so an error arriving with its W1C is not lost.
      ovr_q <= ovr_set   | (ovr_q & ~clr_ovr);
      fe_q  <= frame_set | (fe_q  & ~clr_fe);

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)      count_q <= count_q + CNT_W'(1);
        else if (!push_ok && pop) count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_apb_uart_rx : register table, directed frame sequences and random
// traffic against a queue model for apb_uart_rx
// Revision 1.0
// ============================================================================
module tb_apb_uart_rx;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic rx_irq;

  apb_uart_rx_if bus ();

  apb_uart_rx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd1)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .apb    (bus),
    .rx     (rx),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  logic irq_at_ready;

  // Reference model: received bytes in arrival order plus the two sticky flags.
  logic [7:0] mq[$];
  logic       m_ovr, m_fe;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {19'd0, 5'(mq.size()), 3'd0, 1'b0, m_fe, m_ovr,
            1'(mq.size() == DEPTH), 1'(mq.size() != 0)};
  endfunction

  task automatic m_send(input logic [7:0] b, input logic stopv);
    if (!stopv)                m_fe = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else                       m_ovr = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    for (n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.PREADY) break;
    end
    chk("wr_pready_wait", 32'(n), 32'd0);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    #1 chk("rd_pready_first", 32'(bus.PREADY), 32'd0);
    for (n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.PREADY) break;
    end
    chk("rd_pready_wait", 32'(n), 32'd0);
    d = bus.PRDATA;
    irq_at_ready = rx_irq;
    @(posedge clk); #1;
    chk("rd_pready_drop", 32'(bus.PREADY), 32'd0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    chk(nm, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv, input int div);
    int bp;
    bp = 16 * (div + 1);
    @(negedge clk);
    rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bp) @(negedge clk);
    end
    rx = stopv;
    repeat (bp) @(negedge clk);
    rx = 1'b1;
    repeat (bp) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, e, w;
    logic [7:0]  b;
    logic        s;
    int          op, div;

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0;  bus.PWDATA = '0;
    do_reset();
    #1;
    chk("reset_prdata", bus.PRDATA, 32'd0);
    chk("reset_pready", 32'(bus.PREADY), 32'd0);
    chk("reset_irq", 32'(rx_irq), 32'd0);

    tbl[0]  = '{1'b0, 5'h08, 32'h0000_0001};
    tbl[1]  = '{1'b0, 5'h0C, 32'h0000_0001};
    tbl[2]  = '{1'b0, 5'h04, 32'h0000_0000};
    tbl[3]  = '{1'b0, 5'h00, 32'h0000_0000};
    tbl[4]  = '{1'b1, 5'h08, 32'hFFFF_1234};
    tbl[5]  = '{1'b0, 5'h08, 32'h0000_1234};
    tbl[6]  = '{1'b1, 5'h0C, 32'hFFFF_FFFF};
    tbl[7]  = '{1'b0, 5'h0C, 32'h0000_0003};
    tbl[8]  = '{1'b0, 5'h10, 32'h0000_0000};
    tbl[9]  = '{1'b1, 5'h18, 32'h0000_DEAD};
    tbl[10] = '{1'b0, 5'h08, 32'h0000_1234};
    tbl[11] = '{1'b1, 5'h04, 32'hFFFF_FFFF};
    tbl[12] = '{1'b0, 5'h04, 32'h0000_0000};
    tbl[13] = '{1'b1, 5'h08, 32'h0000_0001};
    tbl[14] = '{1'b1, 5'h0C, 32'h0000_0001};
    tbl[15] = '{1'b0, 5'h0C, 32'h0000_0001};
    tbl[16] = '{1'b0, 5'h1C, 32'h0000_0000};
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
      else           rd_chk("table_read", tbl[i].addr, tbl[i].data);
    end

    // Basic frame
    send_frame(8'hA5, 1'b1, 1);
    rd_chk("a5_status", 5'h04, 32'h0000_0101);
    rd_chk("a5_data", 5'h00, 32'h0000_00A5);
    rd_chk("a5_status_after", 5'h04, 32'h0000_0000);

    // Framing error and its W1C clear
    send_frame(8'h3C, 1'b0, 1);
    rd_chk("fe_status", 5'h04, 32'h0000_0008);
    apb_write(5'h04, 32'h8);
    rd_chk("fe_cleared", 5'h04, 32'h0000_0000);

    // Overrun: nine frames into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1);
    rd_chk("ovr_status", 5'h04, 32'h0000_0807);
    for (int i = 1; i <= 8; i++) rd_chk("ovr_data", 5'h00, 32'(i));
    rd_chk("ovr_empty_read", 5'h00, 32'h0);
    rd_chk("ovr_sticky", 5'h04, 32'h0000_0004);
    apb_write(5'h04, 32'h4);
    rd_chk("ovr_cleared", 5'h04, 32'h0);

    // False start: short low glitch, busy while in START, then back to idle
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    rd_chk("false_start_busy", 5'h04, 32'h0000_0010);
    repeat (60) @(negedge clk);
    rd_chk("false_start_idle", 5'h04, 32'h0);

    // Interrupt and flush
    apb_write(5'h0C, 32'h3);
    #1 chk("irq_before", 32'(rx_irq), 32'd0);
    send_frame(8'h7E, 1'b1, 1);
    chk("irq_raised", 32'(rx_irq), 32'd1);
    rd_chk("irq_data", 5'h00, 32'h7E);
    chk("irq_at_ready", 32'(irq_at_ready), 32'd1);
    chk("irq_fell", 32'(rx_irq), 32'd0);
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    rd_chk("flush_pre", 5'h04, 32'h0000_0201);
    apb_write(5'h0C, 32'h7);
    rd_chk("flush_post", 5'h04, 32'h0);
    rd_chk("flush_ctrl", 5'h0C, 32'h3);
    chk("flush_irq", 32'(rx_irq), 32'd0);

    // Reset in the middle of a frame (bits 4..7 high so no spurious start follows)
    apb_write(5'h08, 32'h2);
    fork
      send_frame(8'hF0, 1'b1, 2);
      begin
        repeat (48 * 5 + 16) @(negedge clk);
        rd_chk("preset_busy", 5'h04, 32'h0000_0010);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    rd_chk("preset_baud", 5'h08, 32'h1);
    rd_chk("preset_ctrl", 5'h0C, 32'h1);
    rd_chk("preset_status", 5'h04, 32'h0);
    send_frame(8'h55, 1'b1, 1);
    rd_chk("preset_55_status", 5'h04, 32'h0000_0101);
    rd_chk("preset_55_data", 5'h00, 32'h55);
    rd_chk("preset_55_empty", 5'h04, 32'h0);

    // Random traffic against the queue model
    do_reset();
    div = $urandom_range(1, 2);
    apb_write(5'h08, 32'(div));
    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        b = 8'($urandom);
        s = ($urandom_range(0, 5) != 0);
        send_frame(b, s, div);
        m_send(b, s);
      end else if (op < 6) begin
        e = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
        rd_chk("rand_data", 5'h00, e);
      end else if (op < 8) begin
        rd_chk("rand_status", 5'h04, m_status());
      end else if (op == 8) begin
        w = $urandom;
        apb_write(5'h04, w);
        if (w[2]) m_ovr = 1'b0;
        if (w[3]) m_fe  = 1'b0;
      end else begin
        apb_write(5'h0C, 32'h5);
        mq.delete();
      end
    end
    rd_chk("rand_final_status", 5'h04, m_status());
    for (int k = 0; k <= DEPTH; k++) begin
      e = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
      rd_chk("rand_drain", 5'h00, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
